// File: rtl/bufgctrl_seq.sv
`timescale 1ns/1ps
// Control sequencer for a BUFGCTRL global clock mux: gate-off, select, gate-on
// switching with settle periods, plus automatic failover when the active source stops.
module bufgctrl_seq #(
    parameter int SETTLE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic       req_sel,
    output logic       req_ready,
    input  logic       alive0,
    input  logic       alive1,
    output logic       ce0,
    output logic       ce1,
    output logic       s0,
    output logic       s1,
    output logic       ignore0,
    output logic       ignore1,
    output logic       cur_sel,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       failover,
    output logic [7:0] switch_count
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DISABLE = 2'd1,
        SELECT  = 2'd2,
        ENABLE  = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          tgt, tgt_n;
    logic          cur_n;
    logic [1:0]    alive;
    logic          fo_cond;
    logic [1:0]    ce_n, s_n, ign_n;
    logic          busy_n, done_n, err_n, fo_n;
    logic [7:0]    count_n;

    assign alive     = {alive1, alive0};
    assign fo_cond   = !alive[cur_sel] && alive[~cur_sel];
    assign req_ready = (state == IDLE) && !fo_cond;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        tgt_n   = tgt;
        cur_n   = cur_sel;
        count_n = switch_count;
        done_n  = 1'b0;
        err_n   = 1'b0;
        fo_n    = 1'b0;

        case (state)
            IDLE: begin
                if (fo_cond) begin
                    state_n = DISABLE;
                    cnt_n   = CNT_ONE;
                    tgt_n   = ~cur_sel;
                    fo_n    = 1'b1;
                end else if (req_valid) begin
                    if (req_sel == cur_sel) begin
                        done_n = 1'b1;
                    end else if (!alive[req_sel]) begin
                        err_n = 1'b1;
                    end else begin
                        state_n = DISABLE;
                        cnt_n   = CNT_ONE;
                        tgt_n   = req_sel;
                    end
                end
            end
            DISABLE: begin
                if (cnt == CNT_LAST) state_n = SELECT;
                else                 cnt_n   = cnt + CNT_ONE;
            end
            SELECT: begin
                state_n = ENABLE;
                cnt_n   = CNT_ONE;
            end
            ENABLE: begin
                if (cnt == CNT_LAST) begin
                    state_n = IDLE;
                    cur_n   = tgt;
                    done_n  = 1'b1;
                    count_n = switch_count + 8'd1;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            default: state_n = IDLE;
        endcase

        // BUFGCTRL controls are decoded from the next state so they leave as flop outputs.
        ce_n  = 2'b00;
        s_n   = 2'b00;
        ign_n = 2'b00;
        case (state_n)
            IDLE: begin
                ce_n[cur_n] = 1'b1;
                s_n[cur_n]  = 1'b1;
            end
            DISABLE: begin
                s_n[cur_n]   = 1'b1;
                ign_n[cur_n] = 1'b1;
            end
            SELECT: begin
                s_n[tgt_n]   = 1'b1;
                ign_n[cur_n] = 1'b1;
            end
            ENABLE: begin
                ce_n[tgt_n]  = 1'b1;
                s_n[tgt_n]   = 1'b1;
                ign_n[cur_n] = 1'b1;
            end
            default: begin
                ce_n = 2'b00;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            tgt          <= 1'b0;
            cur_sel      <= 1'b0;
            ce0          <= 1'b1;
            ce1          <= 1'b0;
            s0           <= 1'b1;
            s1           <= 1'b0;
            ignore0      <= 1'b0;
            ignore1      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            failover     <= 1'b0;
            switch_count <= 8'd0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            tgt          <= tgt_n;
            cur_sel      <= cur_n;
            ce0          <= ce_n[0];
            ce1          <= ce_n[1];
            s0           <= s_n[0];
            s1           <= s_n[1];
            ignore0      <= ign_n[0];
            ignore1      <= ign_n[1];
            busy         <= busy_n;
            done         <= done_n;
            err          <= err_n;
            failover     <= fo_n;
            switch_count <= count_n;
        end
    end

endmodule

// File: tb/tb_bufgctrl_seq.sv
`timescale 1ns/1ps
// Self-checking bench for bufgctrl_seq: vector table, directed multi-cycle
// sequences and randomized traffic against a timing-table reference model.
module tb_bufgctrl_seq;

    localparam int S   = 8;
    localparam int SEQ = 2 * S + 2;

    logic       clk = 1'b0;
    logic       rst, req_valid, req_sel, alive0, alive1;
    logic       req_ready, ce0, ce1, s0, s1, ignore0, ignore1;
    logic       cur_sel, busy, done, err, failover;
    logic [7:0] switch_count;

    always #5 clk = ~clk;

    bufgctrl_seq #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_sel(req_sel),
        .req_ready(req_ready), .alive0(alive0), .alive1(alive1),
        .ce0(ce0), .ce1(ce1), .s0(s0), .s1(s1),
        .ignore0(ignore0), .ignore1(ignore1), .cur_sel(cur_sel),
        .busy(busy), .done(done), .err(err), .failover(failover),
        .switch_count(switch_count)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: a sequence is "elapsed cycles since acceptance" m_k,
    // and the outputs follow directly from the published timing table.
    bit m_valid = 0;
    bit m_busy, m_cur, m_tgt, m_done, m_err, m_fo;
    int m_k, m_cnt;
    bit last_ready;
    int done_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_fo_cond(input bit cur, input bit a0, input bit a1);
        bit ac, ao;
        ac = cur ? a1 : a0;
        ao = cur ? a0 : a1;
        return !ac && ao;
    endfunction

    function automatic bit m_ready();
        return !m_busy && !m_fo_cond(m_cur, alive0, alive1);
    endfunction

    task automatic model_edge();
        bit a_req;
        m_done = 0; m_err = 0; m_fo = 0;
        if (rst) begin
            m_busy = 0; m_cur = 0; m_tgt = 0; m_cnt = 0; m_k = 0;
        end else if (!m_busy) begin
            a_req = req_sel ? alive1 : alive0;
            if (m_fo_cond(m_cur, alive0, alive1)) begin
                m_busy = 1; m_k = 1; m_tgt = !m_cur; m_fo = 1;
            end else if (req_valid) begin
                if (req_sel == m_cur)  m_done = 1;
                else if (!a_req)       m_err = 1;
                else begin
                    m_busy = 1; m_k = 1; m_tgt = req_sel;
                end
            end
        end else begin
            m_k++;
            if (m_k == SEQ) begin
                m_busy = 0;
                m_cur  = m_tgt;
                m_cnt  = (m_cnt + 1) % 256;
                m_done = 1;
            end
        end
    endtask

    function automatic logic [18:0] model_vec();
        logic [1:0] ce, s, ig;
        ce = 2'b00; s = 2'b00; ig = 2'b00;
        if (!m_busy) begin
            ce[m_cur] = 1'b1;
            s[m_cur]  = 1'b1;
        end else begin
            ig[m_cur] = 1'b1;
            if (m_k <= S)          s[m_cur] = 1'b1;
            else if (m_k == S + 1) s[m_tgt] = 1'b1;
            else begin
                ce[m_tgt] = 1'b1;
                s[m_tgt]  = 1'b1;
            end
        end
        return {ce[0], ce[1], s[0], s[1], ig[0], ig[1], m_cur, m_busy,
                m_done, m_err, m_fo, 8'(m_cnt)};
    endfunction

    function automatic logic [18:0] dut_vec();
        return {ce0, ce1, s0, s1, ignore0, ignore1, cur_sel, busy,
                done, err, failover, switch_count};
    endfunction

    // One control-clock cycle: drive, check combinational ready, clock, check outputs.
    task automatic step(input bit r, input bit v, input bit sel, input bit a0, input bit a1);
        rst = r; req_valid = v; req_sel = sel; alive0 = a0; alive1 = a1;
        #1;
        last_ready = req_ready;
        if (m_valid) check("req_ready", req_ready, m_ready());
        @(posedge clk);
        model_edge();
        m_valid = 1;
        #1;
        check("outputs", dut_vec(), model_vec());
        check("ce_overlap", ce0 & ce1, 0);
        if (done) done_seen++;
        @(negedge clk);
    endtask

    typedef struct {
        bit r, v, sel, a0, a1;
        bit rdy, dn, er, fo, bsy, cur;
    } vec_t;

    vec_t tbl[8];
    logic [18:0] reset_vec;
    bit ra0, ra1;

    initial begin
        rst = 1; req_valid = 0; req_sel = 0; alive0 = 1; alive1 = 1;
        reset_vec = {1'b1, 1'b0, 1'b1, 1'b0, 7'b0, 8'd0};
        @(negedge clk);

        // Reset, then idle: exact reset values, no pulses.
        step(1, 0, 0, 1, 1);
        check("reset_vals", dut_vec(), reset_vec);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 1, 1);
            check("idle_vals", dut_vec(), reset_vec);
        end

        // Single-cycle behaviours that leave the block in IDLE.
        tbl[0] = '{0, 0, 0, 1, 1,  1, 0, 0, 0, 0, 0};
        tbl[1] = '{0, 1, 0, 1, 1,  1, 1, 0, 0, 0, 0};
        tbl[2] = '{0, 1, 1, 1, 0,  1, 0, 1, 0, 0, 0};
        tbl[3] = '{0, 1, 1, 0, 0,  1, 0, 1, 0, 0, 0};
        tbl[4] = '{0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0};
        tbl[5] = '{0, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0};
        tbl[6] = '{1, 1, 1, 1, 1,  1, 0, 0, 0, 0, 0};
        tbl[7] = '{0, 0, 0, 1, 1,  1, 0, 0, 0, 0, 0};
        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].v, tbl[i].sel, tbl[i].a0, tbl[i].a1);
            check($sformatf("tbl%0d_ready", i), last_ready, tbl[i].rdy);
            check($sformatf("tbl%0d_pulses", i),
                  {done, err, failover, busy, cur_sel},
                  {tbl[i].dn, tbl[i].er, tbl[i].fo, tbl[i].bsy, tbl[i].cur});
        end

        // Full switch 0 -> 1.
        for (int k = 1; k <= SEQ; k++) begin
            if (k == 1) step(0, 1, 1, 1, 1);
            else        step(0, 0, 0, 1, 1);
            if (k == 1)       check("sw_ce0_off", {ce0, ce1, busy}, 3'b001);
            if (k == S)       check("sw_s_hold", {s0, s1}, 2'b10);
            if (k == S + 1)   check("sw_s_swap", {s0, s1, ce0, ce1}, 4'b0100);
            if (k == S + 2)   check("sw_ce1_on", {ce0, ce1}, 2'b01);
            if (k == SEQ - 1) check("sw_no_early_done", done, 0);
            if (k == SEQ)     check("sw_done", {done, cur_sel, busy, switch_count}, {3'b110, 8'd1});
        end

        // Failover from I0 to I1 with a conflicting request held.
        step(1, 0, 0, 1, 1);
        for (int k = 1; k <= SEQ; k++) begin
            step(0, 1, 0, 0, 1);
            if (k == 1) begin
                check("fo_ready_low", last_ready, 0);
                check("fo_pulse", {failover, ignore0, busy}, 3'b111);
            end
            if (k == SEQ - 1) check("fo_ignore_held", ignore0, 1);
            if (k == SEQ)     check("fo_done", {done, cur_sel, ignore0, ignore1}, 4'b1100);
        end

        // Reset in the middle of a switch, then a fresh switch.
        step(1, 0, 0, 1, 1);
        done_seen = 0;
        step(0, 1, 1, 1, 1);
        for (int k = 2; k <= 12; k++) step(0, 0, 0, 1, 1);
        step(1, 0, 0, 1, 1);
        check("midrst_vals", dut_vec(), reset_vec);
        for (int k = 0; k < SEQ; k++) step(0, 0, 0, 1, 1);
        check("midrst_no_done", done_seen, 0);
        for (int k = 1; k <= SEQ; k++) begin
            step(0, k == 1, 1, 1, 1);
            if (k == SEQ) check("post_rst_switch", {done, cur_sel, switch_count}, {2'b11, 8'd1});
        end

        // 256 back-to-back alternating switches: counter wraps.
        step(1, 0, 0, 1, 1);
        done_seen = 0;
        for (int i = 0; i < 256 * SEQ; i++) step(0, 1, !m_cur, 1, 1);
        check("b2b_done_count", done_seen, 256);
        check("b2b_wrap", switch_count, 8'd0);

        // Randomized traffic against the reference model.
        ra0 = 1; ra1 = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) ra0 = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) ra1 = ($urandom_range(0, 3) != 0);
            step($urandom_range(0, 299) == 0, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), ra0, ra1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
